// File: rtl/audio_pwm_out.sv
// Audio output stage: one-entry sample holding register, ramped volume scaling,
// and an 8-bit PWM modulator with starvation/drop status pulses.
module audio_pwm_out #(
  parameter int RAMP_DIV = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [3:0] volume,
  input  logic       mute,
  output logic       pwm_out,
  output logic [7:0] level,
  output logic       underrun,
  output logic       overrun
);

  localparam int RAMP_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  logic [7:0]        pwm_cnt;
  logic              hold_full;
  logic [7:0]        hold_reg;
  logic [7:0]        active;
  logic [7:0]        duty_reg;
  logic [3:0]        gain;
  logic [RAMP_W-1:0] ramp_cnt;

  logic              pb;
  logic              ramp_tick;
  logic [3:0]        gain_target;
  logic [7:0]        active_nxt;

  // Centre the byte on zero, apply gain, floor-divide by 16 and re-bias.
  // Worst cases land on 8 and 247, so no clamp is required.
  function automatic logic [7:0] scale_duty(input logic [7:0] smp, input logic [3:0] g);
    logic signed [8:0]  s;
    logic signed [13:0] s_w;
    logic signed [13:0] g_w;
    logic signed [13:0] p;
    logic signed [13:0] q;
    s   = $signed({1'b0, smp}) - 9'sd128;
    s_w = 14'(s);
    g_w = 14'($signed({1'b0, g}));
    p   = s_w * g_w;
    q   = (p >>> 4) + 14'sd128;
    return q[7:0];
  endfunction

  always_comb begin
    pb          = (pwm_cnt == 8'hFF);
    ramp_tick   = (ramp_cnt == RAMP_LAST);
    gain_target = mute ? 4'd0 : volume;
    active_nxt  = (pb && hold_full) ? hold_reg : active;
  end

  // PWM counter and output comparator
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < duty_reg);
    end
  end

  // Holding register, period-boundary transfer and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_reg  <= 8'h80;
      active    <= 8'h80;
      duty_reg  <= 8'd128;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
      if (pb) begin
        duty_reg <= scale_duty(active_nxt, gain);
        if (hold_full) begin
          active <= hold_reg;
        end else begin
          underrun <= 1'b1;
        end
        // The slot frees up on this edge, so a coincident sample always fits.
        if (sample_valid) begin
          hold_reg  <= sample_in;
          hold_full <= 1'b1;
        end else begin
          hold_full <= 1'b0;
        end
      end else if (sample_valid) begin
        if (hold_full) begin
          overrun <= 1'b1;
        end else begin
          hold_reg  <= sample_in;
          hold_full <= 1'b1;
        end
      end
    end
  end

  // Gain ramp: at most one step per tick toward the target, for click-free changes
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt <= '0;
      gain     <= 4'd0;
    end else begin
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      if (ramp_tick) begin
        if (gain < gain_target) begin
          gain <= gain + 4'd1;
        end else if (gain > gain_target) begin
          gain <= gain - 4'd1;
        end
      end
    end
  end

  assign sample_ready = ~hold_full;
  assign level        = duty_reg;

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
Downstream audio stage for the player datapath. Consumes the 8-bit unsigned sample bytes read from the song ROM and converts them to a single-bit PWM stream for the board's audio pin. Samples pass through a one-entry holding register, get volume scaling with a click-free gain ramp for mute and unmute, and are applied once per 256-clock PWM period. Status flags report sample starvation and dropped samples to the control FSMs.

Parameters:
RAMP_DIV, 4096, clocks between gain ramp steps (≥2); benches use 4.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
sample_in  input  8  unsigned sample byte; 0x80 = silence midpoint.
sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
sample_ready  output  1  high when the holding register is empty; equals ~hold_full.
volume  input  4  target gain, 0..15; sampled continuously.
mute  input  1  level; forces the gain target to 0.
pwm_out  output  1  registered PWM bit.
level  output  8  current duty value (equals duty_reg).
underrun  output  1  one-cycle pulse: period ended with the holding register empty.
overrun  output  1  one-cycle pulse: a sample was dropped.

Behaviour:
- Reset (synchronous, priority over everything), values from the next edge:
  - pwm_cnt=0, hold_full=0, hold_reg=0x80, active=0x80, gain=0, ramp_cnt=0.
  - duty_reg=128, pwm_out=0, underrun=0, overrun=0, level=128.
  - Reset mid-period abandons the period; the first new period starts at pwm_cnt=0.
- PWM counter:
  - pwm_cnt is 8 bits, free-running 0..255, wraps to 0.
  - A period boundary (pb) is the cycle where pwm_cnt==255.
- Holding register:
  - sample_valid with hold_full=0: hold_reg<=sample_in, hold_full<=1.
  - sample_valid with hold_full=1 and not pb: sample is dropped, hold_reg is unchanged, overrun pulses next cycle.
- Period boundary transfer (decision uses the registered hold_full):
  - If hold_full: active<=hold_reg, hold_full<=0.
  - Else: active is unchanged (last sample repeats), underrun pulses next cycle.
  - sample_valid on pb with hold_full=1: the old hold moves to active and the new sample loads into hold. hold_full stays 1; no overrun.
  - sample_valid on pb with hold_full=0: underrun pulses and the new sample loads into hold.
- Gain ramp:
  - ramp_cnt counts 0..RAMP_DIV-1 and wraps. A tick occurs when ramp_cnt==RAMP_DIV-1.
  - target = mute ? 0 : volume.
  - On a tick: gain<target → gain+1; gain>target → gain−1; else hold.
  - Gain changes by at most 1 per tick. Changing volume while unmuted also ramps.
  - After reset, gain fades in from 0.
- Scaling (combinational; the result is registered on pb):
  - s = {1'b0,next_active} − 128, as signed 9-bit. next_active is the value active takes on this pb.
  - p = s × gain, signed.
  - d = (p >>> 4) + 128. The shift is arithmetic, i.e. floor.
  - duty_reg<=d[7:0] on pb, using the gain value held in that cycle.
  - Range proof: max 127×15=1905 → 119 → 247; min −128×15=−1920 → −120 → 8. No saturation logic is needed.
- Output:
  - pwm_out <= (pwm_cnt < duty_reg) every cycle, i.e. 1-cycle latency.
  - pwm_out is high for exactly duty_reg cycles per 256-cycle window, starting one cycle after pwm_cnt returns to 0.
  - duty_reg only changes on pb, so there are no mid-period glitches.
- Flags: underrun and overrun are single-cycle pulses and are never asserted simultaneously from one cause.

Test Plan:
1. Reset, then volume=15, mute=0, RAMP_DIV=4, no samples → gain steps 0→15 over 15 ticks (60 clocks); level stays 128; underrun pulses once per period.
2. Gain 15, feed 0xFF before a pb → next period level=247, pwm_out high 247 of 256 cycles; feed 0x00 → level=8.
3. Gain 15, sample 0x40 → s=−64, p=−960, >>>4=−60 → level=68; at gain 1, sample 0x81 → level=128 (floor of 1/16).
4. Two sample_valid strobes mid-period with no pb between → second strobe gives overrun=1 for one cycle; the first sample reaches level at the next pb.
5. sample_valid exactly on pb with hold_full=1 → old sample becomes active, new sample is held, sample_ready=0, no overrun.
6. mute asserted at gain 15 → gain decrements to 0 in 15 ticks, level converges to 128 for any sample; assert reset mid-period → all outputs return to their reset values next cycle.
